// File: rtl/adder_err_pkg.sv
// Shared types, default sizes and a saturating-add helper for the adder error
// monitor.
package adder_err_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;

  // Widest accumulator the saturating helper supports.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } err_state_t;

  // Adds two values that are each below 2^accW and clamps the result to
  // 2^accW - 1. A wrap of the 64-bit sum (only possible when accW == 64) also
  // clamps.
  function automatic logic [SAT_W-1:0] satAdd(input logic [SAT_W-1:0] acc,
                                              input logic [SAT_W-1:0] inc,
                                              input int unsigned      accW);
    logic [SAT_W-1:0] limit;
    logic [SAT_W-1:0] total;
    limit = (accW >= SAT_W) ? '1 : ((SAT_W'(1) << accW) - SAT_W'(1));
    total = acc + inc;
    return ((total > limit) || (total < acc)) ? limit : total;
  endfunction

endpackage

// File: rtl/adder_error_monitor_abs_diff.sv
// Combinational unsigned absolute difference |x - y| with a mismatch flag.
module abs_diff #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         mismatch
);

  // Subtracting the smaller from the larger keeps the result within W bits.
  assign diff     = (x >= y) ? (x - y) : (y - x);
  assign mismatch = (x != y);

endmodule

// File: rtl/adder_error_monitor.sv
// Error-characterisation stage for approximate adders: counts mismatches,
// accumulates a saturating error-distance sum and tracks the maximum over a
// programmed campaign of samples.
module adder_error_monitor
  import adder_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   approx_sum,
  input  logic [WIDTH:0]   exact_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed,
  output logic [CNT_W-1:0] sample_count
);

  err_state_t       state;
  err_state_t       nextState;
  logic [CNT_W-1:0] target;
  logic             accept;
  logic             lastAccept;
  logic             startAccepted;

  logic [WIDTH:0]   diffComb;
  logic             mismatchComb;

  logic             s1Valid;
  logic [WIDTH:0]   s1Ed;
  logic             s1Mismatch;

  assign in_ready      = (state == RUN);
  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);
  assign startAccepted = (state == IDLE) && start;
  assign accept        = in_valid && in_ready;
  assign lastAccept    = accept && ((sample_count + CNT_W'(1)) == target);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastAccept) begin
          nextState = DRAIN;
        end
      end
      // Stage 2 never stalls, so whatever stage 1 holds on entry retires at the
      // next edge and the pipeline is empty one cycle later.
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target       <= '0;
      sample_count <= '0;
    end else if (startAccepted) begin
      target       <= n_samples;
      sample_count <= '0;
    end else if (accept) begin
      sample_count <= sample_count + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: absolute difference
  // ---------------------------------------------------------------------------
  abs_diff #(
    .W(WIDTH + 1)
  ) absDiffInst (
    .x       (approx_sum),
    .y       (exact_sum),
    .diff    (diffComb),
    .mismatch(mismatchComb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid    <= 1'b0;
      s1Ed       <= '0;
      s1Mismatch <= 1'b0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Ed       <= diffComb;
        s1Mismatch <= mismatchComb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulators, cleared on an accepted start and held otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (startAccepted) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (s1Valid) begin
      // err_count is bounded by target, so a plain increment cannot wrap.
      err_count <= err_count + CNT_W'(s1Mismatch);
      sum_ed    <= ACC_W'(satAdd(SAT_W'(sum_ed), SAT_W'(s1Ed), ACC_W));
      if (s1Ed > max_ed) begin
        max_ed <= s1Ed;
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed self-checking bench: a default-sized monitor and an 8-bit-accumulator
// copy share one stimulus stream.
module tb_adder_error_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;
  localparam int SAT_ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;

  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [WIDTH:0]   max_ed;
  logic [CNT_W-1:0] sample_count;

  logic                 satInReady;
  logic                 satBusy;
  logic                 satDone;
  logic [CNT_W-1:0]     satErrCount;
  logic [SAT_ACC_W-1:0] satSumEd;
  logic [WIDTH:0]       satMaxEd;
  logic [CNT_W-1:0]     satSampleCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_error_monitor #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .approx_sum  (approx_sum),
    .exact_sum   (exact_sum),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .sample_count(sample_count)
  );

  adder_error_monitor #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ACC_W(SAT_ACC_W)
  ) dutSat (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (satInReady),
    .approx_sum  (approx_sum),
    .exact_sum   (exact_sum),
    .busy        (satBusy),
    .done        (satDone),
    .err_count   (satErrCount),
    .sum_ed      (satSumEd),
    .max_ed      (satMaxEd),
    .sample_count(satSampleCount)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance past n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResults(input string tag, input logic [63:0] expErr,
                              input logic [63:0] expSum, input logic [63:0] expMax,
                              input logic [63:0] expCount);
    check({tag, ".err_count"}, err_count, expErr);
    check({tag, ".sum_ed"}, sum_ed, expSum);
    check({tag, ".max_ed"}, max_ed, expMax);
    check({tag, ".sample_count"}, sample_count, expCount);
  endtask

  task automatic startCampaign(input logic [CNT_W-1:0] n);
    n_samples = n;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic setPair(input logic [WIDTH:0] a, input logic [WIDTH:0] e);
    approx_sum = a;
    exact_sum  = e;
    in_valid   = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    n_samples  = '0;
    in_valid   = 1'b0;
    approx_sum = '0;
    exact_sum  = '0;

    // Reset defaults
    tick(2);
    check("rst.in_ready", in_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    checkResults("rst", 0, 0, 0, 0);
    rst = 1'b0;
    setPair(9'd3, 9'd1);
    tick(3);
    check("idle_valid.sample_count", sample_count, 0);
    check("idle_valid.in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Basic campaign: four back-to-back pairs
    startCampaign(16'd4);
    check("basic.in_ready", in_ready, 1);
    check("basic.busy", busy, 1);
    setPair(9'd10, 9'd10);
    tick(1);
    setPair(9'd255, 9'd256);
    tick(1);
    setPair(9'd300, 9'd290);
    tick(1);
    setPair(9'd0, 9'd0);
    tick(1);
    in_valid = 1'b0;
    check("basic.drain_in_ready", in_ready, 0);
    check("basic.drain_done", done, 0);
    check("basic.drain_busy", busy, 1);
    tick(1);
    check("basic.done", done, 1);
    check("basic.busy_at_done", busy, 0);
    checkResults("basic", 2, 11, 10, 4);
    tick(1);
    check("basic.done_pulse", done, 0);
    checkResults("basic_held", 2, 11, 10, 4);

    // Stalls: gaps of 0, 2 and 5 cycles before each (7,5) pair
    startCampaign(16'd3);
    setPair(9'd7, 9'd5);
    tick(1);
    in_valid = 1'b0;
    tick(2);
    check("stall.count_mid", sample_count, 1);
    check("stall.err_mid", err_count, 1);
    setPair(9'd7, 9'd5);
    tick(1);
    in_valid = 1'b0;
    tick(5);
    check("stall.ready_in_gap", in_ready, 1);
    setPair(9'd7, 9'd5);
    tick(1);
    in_valid = 1'b0;
    check("stall.ready_drop", in_ready, 0);
    tick(1);
    check("stall.done", done, 1);
    checkResults("stall", 3, 6, 2, 3);
    tick(1);

    // Saturation: the 8-bit accumulator clamps, the 32-bit one does not
    startCampaign(16'd3);
    setPair(9'd511, 9'd0);
    tick(3);
    in_valid = 1'b0;
    tick(1);
    check("sat.done", satDone, 1);
    check("sat.sum_ed", satSumEd, 255);
    check("sat.max_ed", satMaxEd, 511);
    check("sat.err_count", satErrCount, 3);
    check("sat.wide_sum_ed", sum_ed, 1533);
    tick(1);

    // Zero-length campaign clears previous results
    startCampaign(16'd0);
    check("zero.done", done, 1);
    check("zero.busy", busy, 0);
    checkResults("zero", 0, 0, 0, 0);
    tick(1);
    check("zero.done_pulse", done, 0);

    // Start during RUN is ignored
    startCampaign(16'd2);
    setPair(9'd1, 9'd3);
    tick(1);
    in_valid  = 1'b0;
    n_samples = 16'd9;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    check("ign_start.busy", busy, 1);
    check("ign_start.count", sample_count, 1);
    setPair(9'd4, 9'd4);
    tick(1);
    in_valid = 1'b0;
    tick(1);
    check("ign_start.done", done, 1);
    checkResults("ign_start", 1, 2, 2, 2);
    tick(1);

    // Mid-campaign reset discards everything asynchronously
    startCampaign(16'd5);
    setPair(9'd20, 9'd10);
    tick(2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.in_ready", in_ready, 0);
    check("midrst.done", done, 0);
    checkResults("midrst", 0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("midrst.no_done", done, 0);
    check("midrst.idle", busy, 0);

    // Fresh single-sample campaign after reset
    startCampaign(16'd1);
    setPair(9'd1, 9'd2);
    tick(1);
    in_valid = 1'b0;
    check("post_rst.drain", in_ready, 0);
    tick(1);
    check("post_rst.done", done, 1);
    checkResults("post_rst", 1, 1, 1, 1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
# adder_error_monitor

Sequential error-characterisation stage placed directly downstream of the approximate adder chains. It consumes one (approximate sum, exact sum) pair per handshake and accumulates error statistics over a programmed campaign of N samples:

- error count
- summed error distance
- maximum error distance

At the end of the campaign it pulses `done`, and the results stay readable until the next campaign starts.

## Interface
- `WIDTH`, 8, operand width of the adder under test; sums are `WIDTH+1` bits including carry-out
- `CNT_W`, 16, width of the sample counter and error counter
- `ACC_W`, 32, width of the summed-error-distance accumulator
- `clk`  in  1  rising-edge clock, the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a campaign; sampled only in IDLE
- `n_samples`  in  `CNT_W`  campaign length, latched on accepted `start`
- `in_valid`  in  1  sample pair present
- `in_ready`  out  1  monitor accepts a sample this cycle
- `approx_sum`  in  `WIDTH+1`  approximate adder output {cOut, s}
- `exact_sum`  in  `WIDTH+1`  reference adder output
- `busy`  out  1  campaign in progress (RUN or DRAIN)
- `done`  out  1  one-cycle pulse at campaign end
- `err_count`  out  `CNT_W`  samples with `approx_sum != exact_sum`
- `sum_ed`  out  `ACC_W`  sum of |approx − exact|, saturating
- `max_ed`  out  `WIDTH+1`  largest |approx − exact| seen
- `sample_count`  out  `CNT_W`  samples accepted in current/last campaign

## Operation
States and transitions:
- **IDLE:** `in_ready=0`. `start=1` latches `n_samples` into `target`, clears `err_count`, `sum_ed`, `max_ed` and `sample_count`, then moves to RUN. If the latched `n_samples==0`, it goes straight to DONE instead.
- **RUN:** `in_ready=1`.
  - An accept is `in_valid & in_ready`.
  - Each accept increments `sample_count`.
  - The accept that makes `sample_count==target` moves the FSM to DRAIN.
- **DRAIN:** `in_ready=0`. Waits until the pipeline holds no valid sample, then moves to DONE.
- **DONE:** `done=1` for exactly one cycle, then IDLE. Results are held until the next accepted `start`.

Datapath, two registered stages:
- **Stage 1 (abs_diff):** `ed = |approx_sum − exact_sum|` in `WIDTH+1` bits unsigned. This cannot overflow because both operands are `WIDTH+1` bits unsigned. `mismatch = (ed != 0)`.
- **Stage 2 (accumulate):**
  - `err_count += mismatch`
  - `sum_ed = min(sum_ed + ed, 2^ACC_W − 1)`
  - `max_ed = max(max_ed, ed)`

Other rules:
- `err_count` cannot wrap, since it is at most `target`, which fits in `CNT_W`.
- `start` is ignored in RUN, DRAIN and DONE.
- `in_valid` outside RUN is ignored; no sample is captured.

## Timing
- Reset values: state IDLE; `in_ready`, `busy` and `done` all 0; `err_count`, `sum_ed`, `max_ed` and `sample_count` all 0; pipeline valid bits 0.
- Reset mid-campaign: all of the above apply immediately, asynchronously. Partial results are discarded and no `done` is issued.
- Start: `start` accepted at edge t → RUN, with `in_ready=1` from cycle t+1.
- Per-sample latency: sample accepted at edge t → stage-1 register at t+1 → accumulators updated at t+2.
- Throughput: one sample per cycle while `in_valid` is held.
- Last sample: accepted at edge t → DRAIN from t+1 (`in_ready=0`) → accumulators final at t+2 → `done` high during cycle t+2..t+3, i.e. state DONE after edge t+2.
- End of campaign: `busy` falls in the same cycle `done` rises.
- Zero-length campaign: `start` with `n_samples=0` → `done` one cycle after `start` is accepted, with all results 0.

## Structure
- Package `adder_err_pkg` holds:
  - the state enum `err_state_t` {IDLE, RUN, DRAIN, DONE}
  - default `WIDTH`/`CNT_W`/`ACC_W` constants
  - a saturating-add helper function
- One sub-module, `abs_diff`, is natural: it is combinational `|x−y|` plus the mismatch flag, parameterised by width, and is instantiated in stage 1.
- The FSM, counters and accumulators live in the top module.

## Test plan
- **Reset defaults:** assert `rst` → all outputs 0, state IDLE; `in_valid=1` with `start=0` → `sample_count` stays 0.
- **Basic campaign:** `n_samples=4`, `WIDTH=8`, pairs (10,10) (255,256) (300,290) (0,0) back-to-back → `err_count=2`, `sum_ed=11`, `max_ed=10`, `sample_count=4`, `done` exactly 2 cycles after the 4th accept.
- **Stalls:** `n_samples=3` with `in_valid` gaps of 0, 2 and 5 cycles, all pairs (7,5) → `err_count=3`, `sum_ed=6`, `max_ed=2`; `in_ready` drops the cycle after the 3rd accept.
- **Saturation:** `ACC_W=8`, `n_samples=3`, pairs (511,0) ×3 → `sum_ed=255`, `max_ed=511`, `err_count=3`.
- **Zero length and ignored start:** `n_samples=0` → `done` the cycle after `start`, all results 0. `start` pulsed during RUN → no restart, counts unaffected.
- **Mid-campaign reset:** assert `rst` after 2 of 5 samples → outputs 0 immediately, no `done`. A new campaign with `n_samples=1` and pair (1,2) → `err_count=1`, `sum_ed=1`.
